keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_timer.sv | 23 ++
 rtl/keypad_scanner.sv | 119 +++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, key map and row decode helper for the keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    typedef struct packed {
        logic       single;
        logic [1:0] idx;
    } row_info_t;

    // Indexed as KEYMAP[column][row].
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h4, 4'h7, 4'h0},
        '{4'h2, 4'h5, 4'h8, 4'hF},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

    function automatic row_info_t row_info(input logic [3:0] r);
        row_info_t ri;
        ri.single = (r == 4'b1110) || (r == 4'b1101) || (r == 4'b1011) || (r == 4'b0111);
        ri.idx    = !r[0] ? 2'd0 : !r[1] ? 2'd1 : !r[2] ? 2'd2 : 2'd3;
        return ri;
    endfunction

endpackage

// File: rtl/keypad_timer.sv
// keypad_timer: clearable saturating counter flagging when the count reaches a given limit.
module keypad_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= clr ? '0 : (&cnt ? cnt : cnt + W'(1));
    end

    assign tc = cnt >= limit;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad column scanner with press/release debounce.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int clk_freq    = 125_000_000,
    parameter int stable_time = 1000,
    parameter int scan_time   = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int STABLE_CYCLES = clk_freq / 1_000_000 * stable_time;
    localparam int SCAN_CYCLES   = clk_freq / 1_000_000 * scan_time;
    localparam int MAX_CYCLES    = STABLE_CYCLES > SCAN_CYCLES ? STABLE_CYCLES : SCAN_CYCLES;
    localparam int CNT_W         = MAX_CYCLES > 1 ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SCAN_LIM   = CNT_W'(SCAN_CYCLES - 1);

    state_t     state, state_n;
    logic [1:0] idx, idx_n;
    logic [3:0] snap, snap_n, code_n;
    logic [3:0] sync1, row_s;
    logic       valid_n, clr, tc;
    logic [CNT_W-1:0] limit;
    row_info_t  ri;

    keypad_timer #(.W(CNT_W)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .limit(limit),
        .tc   (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 4'b1111;
            row_s     <= 4'b1111;
            state     <= SCAN;
            idx       <= 2'd0;
            snap      <= 4'b1111;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
        end else begin
            sync1     <= row;
            row_s     <= sync1;
            state     <= state_n;
            idx       <= idx_n;
            snap      <= snap_n;
            key_code  <= code_n;
            key_valid <= valid_n;
        end
    end

    assign ri = row_info(snap);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        snap_n  = snap;
        code_n  = key_code;
        valid_n = 1'b0;
        clr     = 1'b0;
        limit   = state == SCAN ? SCAN_LIM : STABLE_LIM;
        case (state)
            SCAN: begin
                if (tc) begin
                    clr = 1'b1;
                    if (row_s == 4'b1111) begin
                        idx_n = idx + 2'd1;
                    end else begin
                        snap_n  = row_s;
                        state_n = DEBOUNCE;
                    end
                end
            end
            DEBOUNCE: begin
                if (row_s != snap) begin
                    clr     = 1'b1;
                    state_n = SCAN;
                end else if (tc) begin
                    clr     = 1'b1;
                    state_n = HELD;
                    // Multi-key chords are held off without reporting a code.
                    if (ri.single) begin
                        code_n  = KEYMAP[idx][ri.idx];
                        valid_n = 1'b1;
                    end
                end
            end
            HELD: begin
                if (row_s == 4'b1111) begin
                    clr     = 1'b1;
                    state_n = RELEASE;
                end
            end
            RELEASE: begin
                if (row_s != 4'b1111) begin
                    state_n = HELD;
                end else if (tc) begin
                    clr     = 1'b1;
                    idx_n   = idx + 2'd1;
                    state_n = SCAN;
                end
            end
            default: state_n = SCAN;
        endcase
    end

    assign col      = ~(4'b0001 << idx);
    assign key_held = (state == HELD) || (state == RELEASE);

endmodule
